// File: rtl/shared_bus_responder_if.sv
// Shared bus responder signal bundle: CPU-side multiplexed bus,
// phase clocks, external RAM port and latch read-back.
interface shared_bus_responder_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              CLK_1H;
   logic              CLK_2H;
   logic              CLK_S2H;
   logic [ADDR_W-1:0] A;
   logic              nWE;
   logic              nLATCH0;
   logic              nLATCH1;
   logic [DATA_W-1:0] MDI;
   logic [DATA_W-1:0] SDI;
   logic [ADDR_W-1:0] RAM_A;
   logic [DATA_W-1:0] RAM_DI;
   logic [DATA_W-1:0] RAM_DO;
   logic              RAM_nCE;
   logic              RAM_nWE;
   logic              RAM_nOE;
   logic [DATA_W-1:0] DL0;
   logic [DATA_W-1:0] DL1;
   logic              DL0_SRC;
   logic              DL1_SRC;
   logic              DONE;

   modport slave (
      input  A, nWE, nLATCH0, nLATCH1, MDI, SDI, RAM_DO,
      output CLK_1H, CLK_2H, CLK_S2H,
      output RAM_A, RAM_DI, RAM_nCE, RAM_nWE, RAM_nOE,
      output DL0, DL1, DL0_SRC, DL1_SRC, DONE
   );

   modport master (
      output A, nWE, nLATCH0, nLATCH1, MDI, SDI, RAM_DO,
      input  CLK_1H, CLK_2H, CLK_S2H,
      input  RAM_A, RAM_DI, RAM_nCE, RAM_nWE, RAM_nOE,
      input  DL0, DL1, DL0_SRC, DL1_SRC, DONE
   );
endinterface

// File: rtl/shared_bus_responder.sv
// Far-end responder of the time-multiplexed master/slave shared bus:
// phase clock generation, per-slot RAM access and latch read-back.
module shared_bus_responder #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input logic                   CLK_6M,
   input logic                   nRST,
   shared_bus_responder_if.slave bus
);
   typedef enum logic [1:0] {
      PH_SADR = 2'd0,
      PH_SSTB = 2'd1,
      PH_MADR = 2'd2,
      PH_MSTB = 2'd3
   } ph_t;

   ph_t               r_ph;
   ph_t               w_ph_nxt;
   logic              r_run;
   logic [ADDR_W-1:0] r_a;
   logic [DATA_W-1:0] r_wd;
   logic [DATA_W-1:0] r_dl0;
   logic [DATA_W-1:0] r_dl1;
   logic              r_we;
   logic              r_l0;
   logic              r_l1;
   logic              r_slot;
   logic              r_act;
   logic              r_nce;
   logic              r_nwe;
   logic              r_noe;
   logic              r_src0;
   logic              r_src1;
   logic              r_done;
   logic              w_we;
   logic              w_l0;
   logic              w_l1;
   logic              w_act;
   logic              w_cap;
   logic              w_stb;
   logic              w_cmp;

   assign w_we  = ~bus.nWE;
   assign w_l0  = ~bus.nLATCH0;
   assign w_l1  = ~bus.nLATCH1;
   assign w_act = w_we | w_l0 | w_l1;
   assign w_cmp = w_stb & r_act;

   always_ff @(posedge CLK_6M or negedge nRST) begin
      if (!nRST) r_ph <= PH_SADR;
      else       r_ph <= w_ph_nxt;
   end

   // Captures are held off for the frame that starts at reset release.
   always_comb begin
      w_ph_nxt = r_ph;
      w_cap    = 1'b0;
      w_stb    = 1'b0;
      unique case (r_ph)
         PH_SADR: begin
            w_ph_nxt = PH_SSTB;
            w_cap    = r_run;
         end
         PH_SSTB: begin
            w_ph_nxt = PH_MADR;
            w_stb    = 1'b1;
         end
         PH_MADR: begin
            w_ph_nxt = PH_MSTB;
            w_cap    = r_run;
         end
         PH_MSTB: begin
            w_ph_nxt = PH_SADR;
            w_stb    = 1'b1;
         end
         default: w_ph_nxt = PH_SADR;
      endcase
   end

   always_ff @(posedge CLK_6M or negedge nRST) begin
      if (!nRST) begin
         r_run  <= 1'b0;
         r_a    <= '0;
         r_wd   <= '0;
         r_we   <= 1'b0;
         r_l0   <= 1'b0;
         r_l1   <= 1'b0;
         r_slot <= 1'b0;
         r_act  <= 1'b0;
      end else begin
         if (r_ph == PH_MSTB) r_run <= 1'b1;
         if (w_cap) begin
            r_a    <= bus.A;
            r_wd   <= r_ph[1] ? bus.MDI : bus.SDI;
            r_we   <= w_we;
            r_l0   <= w_l0;
            r_l1   <= w_l1;
            r_slot <= r_ph[1];
            r_act  <= w_act;
         end
      end
   end

   // Strobes are precomputed at capture so they are glitch-free registers.
   always_ff @(posedge CLK_6M or negedge nRST) begin
      if (!nRST) begin
         r_nce <= 1'b1;
         r_nwe <= 1'b1;
         r_noe <= 1'b1;
      end else if (w_cap) begin
         r_nce <= ~w_act;
         r_nwe <= ~w_we;
         r_noe <= w_we | ~(w_l0 | w_l1);
      end else begin
         r_nce <= 1'b1;
         r_nwe <= 1'b1;
         r_noe <= 1'b1;
      end
   end

   always_ff @(posedge CLK_6M or negedge nRST) begin
      if (!nRST) begin
         r_dl0  <= '0;
         r_dl1  <= '0;
         r_src0 <= 1'b0;
         r_src1 <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_cmp;
         if (w_cmp && !r_we && r_l0) begin
            r_dl0  <= bus.RAM_DO;
            r_src0 <= r_slot;
         end
         if (w_cmp && !r_we && r_l1) begin
            r_dl1  <= bus.RAM_DO;
            r_src1 <= r_slot;
         end
      end
   end

   assign bus.CLK_1H  = r_ph[0];
   assign bus.CLK_2H  = r_ph[1];
   assign bus.CLK_S2H = r_ph[1];
   assign bus.RAM_A   = r_a;
   assign bus.RAM_DI  = r_wd;
   assign bus.RAM_nCE = r_nce;
   assign bus.RAM_nWE = r_nwe;
   assign bus.RAM_nOE = r_noe;
   assign bus.DL0     = r_dl0;
   assign bus.DL1     = r_dl1;
   assign bus.DL0_SRC = r_src0;
   assign bus.DL1_SRC = r_src1;
   assign bus.DONE    = r_done;
endmodule

// File: tb/tb_shared_bus_responder.sv
// Bench for shared_bus_responder: directed vector table, randomized
// slots against a RAM/latch reference model, and async reset mid-strobe.
module tb_shared_bus_responder;
   logic CLK_6M = 1'b0;
   logic nRST   = 1'b0;

   shared_bus_responder_if #(.ADDR_W(13), .DATA_W(8)) bus ();

   shared_bus_responder #(.ADDR_W(13), .DATA_W(8)) dut (
      .CLK_6M (CLK_6M),
      .nRST   (nRST),
      .bus    (bus)
   );

   always #5 CLK_6M = ~CLK_6M;

   typedef struct {
      logic        nwe;
      logic        nl0;
      logic        nl1;
      logic [12:0] a;
      logic [7:0]  wd;
      logic [7:0]  rdo;
      logic        e_nce;
      logic        e_nwe;
      logic        e_noe;
      logic        e_done;
      logic [7:0]  e_dl0;
      logic [7:0]  e_dl1;
      logic        e_s0;
      logic        e_s1;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic        cur_slot;
   logic [7:0]  mem [0:8191];
   logic [7:0]  ref_mem [0:8191];
   logic        s_nce, s_nwe, s_noe, s_2h;
   logic [12:0] s_a;
   logic [7:0]  s_di;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One slot: drive in address phase, sample strobe cycle, end in next address phase.
   task automatic do_slot(input logic nwe, input logic nl0, input logic nl1,
                          input logic [12:0] a, input logic [7:0] wd,
                          input logic [7:0] rdo, input bit use_mem);
      bus.A       = a;
      bus.nWE     = nwe;
      bus.nLATCH0 = nl0;
      bus.nLATCH1 = nl1;
      bus.MDI     = cur_slot ? wd : ~wd;
      bus.SDI     = cur_slot ? ~wd : wd;
      @(posedge CLK_6M);
      @(negedge CLK_6M);
      bus.RAM_DO = use_mem ? mem[bus.RAM_A] : rdo;
      if (!bus.RAM_nCE && !bus.RAM_nWE) mem[bus.RAM_A] = bus.RAM_DI;
      s_nce = bus.RAM_nCE;
      s_nwe = bus.RAM_nWE;
      s_noe = bus.RAM_nOE;
      s_a   = bus.RAM_A;
      s_di  = bus.RAM_DI;
      s_2h  = bus.CLK_2H;
      bus.nWE     = 1'b1;
      bus.nLATCH0 = 1'b1;
      bus.nLATCH1 = 1'b1;
      @(posedge CLK_6M);
      @(negedge CLK_6M);
      cur_slot = ~cur_slot;
   endtask

   initial begin
      vec_t        tbl [7];
      logic [12:0] pool [8];
      logic        m_we, m_l0, m_l1, m_act, slot;
      logic [7:0]  m_dl0, m_dl1, wd;
      logic        m_s0, m_s1;
      logic [12:0] a;

      tbl[0] = '{1,1,1,13'h0000,8'h00,8'hEE, 1,1,1,0, 8'h00,8'h00,0,0};
      tbl[1] = '{1,1,1,13'h0000,8'h00,8'h11, 1,1,1,0, 8'h00,8'h00,0,0};
      tbl[2] = '{0,1,1,13'h0123,8'h5A,8'hEE, 0,0,1,1, 8'h00,8'h00,0,0};
      tbl[3] = '{1,0,1,13'h1FFF,8'h00,8'hC3, 0,1,0,1, 8'hC3,8'h00,1,0};
      tbl[4] = '{1,0,0,13'h0040,8'h00,8'h81, 0,1,0,1, 8'h81,8'h81,0,0};
      tbl[5] = '{0,1,0,13'h0002,8'h77,8'h99, 0,0,1,1, 8'h81,8'h81,0,0};
      tbl[6] = '{1,1,1,13'h0AAA,8'h00,8'h42, 1,1,1,0, 8'h81,8'h81,0,0};
      pool = '{13'h0000, 13'h0001, 13'h0002, 13'h0003,
               13'h1FFF, 13'h1000, 13'h0AAA, 13'h0555};
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

      bus.A = '0; bus.nWE = 1'b1; bus.nLATCH0 = 1'b1; bus.nLATCH1 = 1'b1;
      bus.MDI = '0; bus.SDI = '0; bus.RAM_DO = '0;
      cur_slot = 1'b0;
      repeat (3) @(negedge CLK_6M);
      chk("rst_1h", 32'(bus.CLK_1H), 0);
      chk("rst_2h", 32'(bus.CLK_2H), 0);
      chk("rst_s2h", 32'(bus.CLK_S2H), 0);
      chk("rst_nce", 32'(bus.RAM_nCE), 1);
      chk("rst_nwe", 32'(bus.RAM_nWE), 1);
      chk("rst_noe", 32'(bus.RAM_nOE), 1);
      chk("rst_ram_a", 32'(bus.RAM_A), 0);
      chk("rst_dl0", 32'(bus.DL0), 0);
      chk("rst_dl1", 32'(bus.DL1), 0);
      chk("rst_done", 32'(bus.DONE), 0);
      nRST = 1'b1;

      for (int k = 1; k <= 8; k++) begin
         @(posedge CLK_6M);
         @(negedge CLK_6M);
         chk("idle_1h", 32'(bus.CLK_1H), 32'(k % 2));
         chk("idle_2h", 32'(bus.CLK_2H), 32'((k / 2) % 2));
         chk("idle_s2h", 32'(bus.CLK_S2H), 32'((k / 2) % 2));
         chk("idle_nce", 32'(bus.RAM_nCE), 1);
         chk("idle_done", 32'(bus.DONE), 0);
      end

      for (int i = 0; i < 7; i++) begin
         slot = cur_slot;
         do_slot(tbl[i].nwe, tbl[i].nl0, tbl[i].nl1, tbl[i].a,
                 tbl[i].wd, tbl[i].rdo, 1'b0);
         chk($sformatf("t%0d_nce", i), 32'(s_nce), 32'(tbl[i].e_nce));
         chk($sformatf("t%0d_nwe", i), 32'(s_nwe), 32'(tbl[i].e_nwe));
         chk($sformatf("t%0d_noe", i), 32'(s_noe), 32'(tbl[i].e_noe));
         chk($sformatf("t%0d_2h", i), 32'(s_2h), 32'(slot));
         if (!tbl[i].e_nce) chk($sformatf("t%0d_ram_a", i), 32'(s_a), 32'(tbl[i].a));
         if (!tbl[i].nwe) chk($sformatf("t%0d_ram_di", i), 32'(s_di), 32'(tbl[i].wd));
         chk($sformatf("t%0d_done", i), 32'(bus.DONE), 32'(tbl[i].e_done));
         chk($sformatf("t%0d_dl0", i), 32'(bus.DL0), 32'(tbl[i].e_dl0));
         chk($sformatf("t%0d_dl1", i), 32'(bus.DL1), 32'(tbl[i].e_dl1));
         chk($sformatf("t%0d_src0", i), 32'(bus.DL0_SRC), 32'(tbl[i].e_s0));
         chk($sformatf("t%0d_src1", i), 32'(bus.DL1_SRC), 32'(tbl[i].e_s1));
      end

      for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];
      m_dl0 = 8'h81; m_dl1 = 8'h81; m_s0 = 1'b0; m_s1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         slot = cur_slot;
         m_we = ($urandom_range(0, 9) < 3);
         m_l0 = $urandom_range(0, 1) == 1;
         m_l1 = $urandom_range(0, 1) == 1;
         a    = pool[$urandom_range(0, 7)];
         wd   = 8'($urandom);
         m_act = m_we | m_l0 | m_l1;
         do_slot(~m_we, ~m_l0, ~m_l1, a, wd, 8'h00, 1'b1);
         if (m_we) ref_mem[a] = wd;
         else begin
            if (m_l0) begin m_dl0 = ref_mem[a]; m_s0 = slot; end
            if (m_l1) begin m_dl1 = ref_mem[a]; m_s1 = slot; end
         end
         chk($sformatf("r%0d_nce", i), 32'(s_nce), 32'(!m_act));
         chk($sformatf("r%0d_nwe", i), 32'(s_nwe), 32'(!m_we));
         chk($sformatf("r%0d_noe", i), 32'(s_noe), 32'(m_we || !(m_l0 || m_l1)));
         if (m_act) chk($sformatf("r%0d_ram_a", i), 32'(s_a), 32'(a));
         if (m_we) chk($sformatf("r%0d_ram_di", i), 32'(s_di), 32'(wd));
         chk($sformatf("r%0d_done", i), 32'(bus.DONE), 32'(m_act));
         chk($sformatf("r%0d_dl0", i), 32'(bus.DL0), 32'(m_dl0));
         chk($sformatf("r%0d_dl1", i), 32'(bus.DL1), 32'(m_dl1));
         chk($sformatf("r%0d_src0", i), 32'(bus.DL0_SRC), 32'(m_s0));
         chk($sformatf("r%0d_src1", i), 32'(bus.DL1_SRC), 32'(m_s1));
      end

      chk("pre_rst_slot", 32'(cur_slot), 1);
      bus.A = 13'h0100; bus.nWE = 1'b0; bus.nLATCH1 = 1'b0;
      bus.MDI = 8'h3C; bus.SDI = 8'hC3;
      @(posedge CLK_6M);
      @(negedge CLK_6M);
      chk("mid_nwe_low", 32'(bus.RAM_nWE), 0);
      #2 nRST = 1'b0;
      #1;
      chk("mid_nwe", 32'(bus.RAM_nWE), 1);
      chk("mid_noe", 32'(bus.RAM_nOE), 1);
      chk("mid_nce", 32'(bus.RAM_nCE), 1);
      chk("mid_1h", 32'(bus.CLK_1H), 0);
      chk("mid_2h", 32'(bus.CLK_2H), 0);
      chk("mid_dl0", 32'(bus.DL0), 0);
      chk("mid_dl1", 32'(bus.DL1), 0);
      chk("mid_done", 32'(bus.DONE), 0);
      bus.nWE = 1'b1; bus.nLATCH1 = 1'b1;
      @(posedge CLK_6M);
      @(negedge CLK_6M);
      nRST = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge CLK_6M);
         @(negedge CLK_6M);
         chk("post_done", 32'(bus.DONE), 0);
         chk("post_dl1", 32'(bus.DL1), 0);
         chk("post_src1", 32'(bus.DL1_SRC), 0);
         chk("post_nce", 32'(bus.RAM_nCE), 1);
         chk("post_1h", 32'(bus.CLK_1H), 32'(k % 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
